// File: rtl/triangle_span_gen_pkg.sv
// gfx_pkg: shared constants, coordinate/fixed-point types and span FSM states
// Contents: COORD_W/FRAC/DIV_CYCLES, coord_t, row_t, fix_t, state_t, fixed-point helpers
package gfx_pkg;
  localparam int COORD_W = 16;
  localparam int FRAC = 16;
  localparam int DIV_CYCLES = COORD_W + 1 + FRAC;
  localparam int FIX_W = COORD_W + 1 + FRAC;
  localparam int CNT_W = $clog2(DIV_CYCLES);
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W:0] row_t;
  typedef logic signed [FIX_W-1:0] fix_t;
  typedef enum logic [2:0] {ST_IDLE, ST_DIV13, ST_DIV12, ST_DIV23, ST_EMIT} state_t;
  function automatic fix_t to_fix(input coord_t x);
    return fix_t'(x) <<< FRAC;
  endfunction
  function automatic coord_t fix_floor(input fix_t v);
    return coord_t'(v >>> FRAC);
  endfunction
  function automatic coord_t cmin(input coord_t a, input coord_t b);
    return a < b ? a : b;
  endfunction
  function automatic coord_t cmax(input coord_t a, input coord_t b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/triangle_span_gen_if.sv
// triangle_span_gen_if: sorted-vertex input and span output handshake bundle
// Signals: vi_* vertices, in_valid/in_ready, span_y/xs/xe/last, span_valid/span_ready, err_unsorted, busy
// Modports: master = upstream/downstream side, slave = span generator
interface triangle_span_gen_if;
  gfx_pkg::coord_t vi_1x, vi_1y, vi_2x, vi_2y, vi_3x, vi_3y;
  logic in_valid, in_ready;
  gfx_pkg::coord_t span_y, span_xs, span_xe;
  logic span_valid, span_ready, span_last, err_unsorted, busy;
  modport master (
    output vi_1x, vi_1y, vi_2x, vi_2y, vi_3x, vi_3y, in_valid, span_ready,
    input  in_ready, span_y, span_xs, span_xe, span_valid, span_last, err_unsorted, busy
  );
  modport slave (
    input  vi_1x, vi_1y, vi_2x, vi_2y, vi_3x, vi_3y, in_valid, span_ready,
    output in_ready, span_y, span_xs, span_xe, span_valid, span_last, err_unsorted, busy
  );
endinterface

// File: rtl/triangle_span_gen_serial_divider.sv
// serial_divider: restoring signed divider, one quotient bit per cycle, fixed DIV_CYCLES latency
// Ports: clk, rst_n, i_start (loads operands and runs first step), i_num, i_den, o_done, o_quo (0 when i_den==0)
module serial_divider
  import gfx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  fix_t i_num,
  input  row_t i_den,
  output logic o_done,
  output fix_t o_quo
);
  localparam int DW = COORD_W + 1;
  logic [FIX_W-1:0] r_quo, w_quo_in, w_num_mag;
  logic [DW-1:0] r_rem, r_den, w_rem_in, w_den_in, w_den_mag, w_diff;
  logic [DW:0] w_sh;
  logic w_ge, r_neg, r_zero;
  logic [CNT_W-1:0] r_left;
  always_comb begin
    w_num_mag = i_num[FIX_W-1] ? -i_num : i_num;
    w_den_mag = i_den[DW-1] ? -i_den : i_den;
    w_rem_in = i_start ? '0 : r_rem;
    w_quo_in = i_start ? w_num_mag : r_quo;
    w_den_in = i_start ? w_den_mag : r_den;
    w_sh = {w_rem_in, w_quo_in[FIX_W-1]};
    w_ge = w_sh >= {1'b0, w_den_in};
    w_diff = w_sh[DW-1:0] - w_den_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_den <= '0;
      r_left <= '0;
      r_neg <= 1'b0;
      r_zero <= 1'b0;
    end else if (i_start || r_left != '0) begin
      r_rem <= w_ge ? w_diff : w_sh[DW-1:0];
      r_quo <= {w_quo_in[FIX_W-2:0], w_ge};
      r_den <= w_den_in;
      r_left <= i_start ? CNT_W'(DIV_CYCLES - 1) : r_left - 1'b1;
      if (i_start) begin
        r_neg <= i_num[FIX_W-1] ^ i_den[DW-1];
        r_zero <= i_den == '0;
      end
    end
  end
  assign o_done = r_left == '0;
  assign o_quo = r_zero ? '0 : fix_t'(r_neg ? -r_quo : r_quo);
endmodule

// File: rtl/triangle_span_gen.sv
// triangle_span_gen: walks a y-sorted triangle and emits one horizontal span per scanline
// Ports: clk, rst_n (async, active-low), bus (triangle_span_gen_if.slave: vertices in, spans out, err_unsorted, busy)
module triangle_span_gen
  import gfx_pkg::*;
(
  input logic clk,
  input logic rst_n,
  triangle_span_gen_if.slave bus
);
  state_t r_state, w_nxt;
  coord_t r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
  coord_t w_ax, w_ay, w_bx, w_by, w_xa, w_xb;
  fix_t r_s13, r_s12, r_s23, r_l, r_s, w_num, w_quo;
  row_t r_y, w_ny, w_den;
  logic r_sel23, r_span_valid, r_in_ready, r_err;
  logic w_accept, w_unsorted, w_take, w_start, w_div_done, w_hs, w_last, w_flat, w_deg, w_hit;
  always_comb begin
    w_unsorted = bus.vi_1y > bus.vi_2y || bus.vi_2y > bus.vi_3y;
    w_accept = bus.in_valid && r_in_ready && r_state == ST_IDLE;
    w_take = w_accept && !w_unsorted;
    w_hs = r_span_valid && bus.span_ready;
    w_last = r_y == row_t'(r_y3);
    w_ny = r_y + row_t'(1);
    w_hit = w_ny == row_t'(r_y2);
    w_flat = r_y1 == r_y2;
    w_deg = r_y1 == r_y3;
    w_xa = fix_floor(r_l);
    w_xb = fix_floor(r_s);
    w_ax = r_state == ST_IDLE ? bus.vi_1x : (r_state == ST_DIV12 ? r_x2 : r_x1);
    w_ay = r_state == ST_IDLE ? bus.vi_1y : (r_state == ST_DIV12 ? r_y2 : r_y1);
    w_bx = r_state == ST_IDLE ? bus.vi_3x : (r_state == ST_DIV12 ? r_x3 : r_x2);
    w_by = r_state == ST_IDLE ? bus.vi_3y : (r_state == ST_DIV12 ? r_y3 : r_y2);
    w_num = (fix_t'(w_bx) - fix_t'(w_ax)) <<< FRAC;
    w_den = row_t'(w_by) - row_t'(w_ay);
    w_start = w_take || (w_div_done && (r_state == ST_DIV13 || r_state == ST_DIV12));
  end
  serial_divider u_div (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(w_start),
    .i_num(w_num),
    .i_den(w_den),
    .o_done(w_div_done),
    .o_quo(w_quo)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_take) w_nxt = ST_DIV13;
      ST_DIV13: if (w_div_done) w_nxt = ST_DIV12;
      ST_DIV12: if (w_div_done) w_nxt = ST_DIV23;
      ST_DIV23: if (w_div_done) w_nxt = ST_EMIT;
      ST_EMIT:  if (w_hs && w_last) w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready = r_in_ready;
    bus.busy = r_state != ST_IDLE;
    bus.err_unsorted = r_err;
    bus.span_valid = r_span_valid;
    bus.span_last = r_span_valid && w_last;
    bus.span_y = coord_t'(r_y);
    bus.span_xs = w_deg ? cmin(cmin(r_x1, r_x2), r_x3) : cmin(w_xa, w_xb);
    bus.span_xe = w_deg ? cmax(cmax(r_x1, r_x2), r_x3) : cmax(w_xa, w_xb);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_err <= 1'b0;
      r_span_valid <= 1'b0;
      {r_x1, r_y1, r_x2, r_y2, r_x3, r_y3} <= '0;
      {r_s13, r_s12, r_s23, r_l, r_s} <= '0;
      r_y <= '0;
      r_sel23 <= 1'b0;
    end else begin
      r_in_ready <= w_nxt == ST_IDLE;
      r_err <= w_accept && w_unsorted;
      r_span_valid <= r_state == ST_EMIT && w_nxt == ST_EMIT;
      if (w_take) begin
        {r_x1, r_y1} <= {bus.vi_1x, bus.vi_1y};
        {r_x2, r_y2} <= {bus.vi_2x, bus.vi_2y};
        {r_x3, r_y3} <= {bus.vi_3x, bus.vi_3y};
      end
      if (w_div_done && r_state == ST_DIV13) r_s13 <= w_quo;
      if (w_div_done && r_state == ST_DIV12) r_s12 <= w_quo;
      if (w_div_done && r_state == ST_DIV23) begin
        r_s23 <= w_quo;
        r_y <= row_t'(r_y1);
        r_l <= to_fix(r_x1);
        r_s <= to_fix(w_flat ? r_x2 : r_x1);
        r_sel23 <= w_flat;
      end else if (r_state == ST_EMIT && w_hs && !w_last) begin
        r_y <= w_ny;
        r_l <= r_l + r_s13;
        r_s <= w_hit ? to_fix(r_x2) : r_s + (r_sel23 ? r_s23 : r_s12);
        r_sel23 <= r_sel23 || w_hit;
      end
    end
  end
endmodule

// File: tb/tb_triangle_span_gen.sv
// tb_triangle_span_gen: directed and randomized triangles checked against a closed-form span model
module tb_triangle_span_gen;
  import gfx_pkg::*;
  typedef struct {int y; int xs; int xe; bit last;} span_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  span_t exp_q[$];
  triangle_span_gen_if bus();
  triangle_span_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic longint slope(input longint dx, input longint dy);
    return dy == 0 ? 0 : (dx * (longint'(1) << FRAC)) / dy;
  endfunction
  task automatic build(input int x1, y1, x2, y2, x3, y3);
    longint one, s13, s12, s23;
    one = longint'(1) << FRAC;
    s13 = slope(x3 - x1, y3 - y1);
    s12 = slope(x2 - x1, y2 - y1);
    s23 = slope(x3 - x2, y3 - y2);
    exp_q.delete();
    for (int y = y1; y <= y3; y++) begin
      longint l, s;
      int a, b;
      span_t e;
      l = x1 * one + s13 * (y - y1);
      s = (y < y2) ? x1 * one + s12 * (y - y1) : x2 * one + s23 * (y - y2);
      a = int'(l >>> FRAC);
      b = int'(s >>> FRAC);
      e.y = y;
      e.xs = a < b ? a : b;
      e.xe = a < b ? b : a;
      e.last = y == y3;
      if (y1 == y3) begin
        e.xs = x1 < x2 ? x1 : x2;
        e.xs = x3 < e.xs ? x3 : e.xs;
        e.xe = x1 > x2 ? x1 : x2;
        e.xe = x3 > e.xe ? x3 : e.xe;
      end
      exp_q.push_back(e);
    end
  endtask
  task automatic drive(input int x1, y1, x2, y2, x3, y3);
    bus.vi_1x = coord_t'(x1);
    bus.vi_1y = coord_t'(y1);
    bus.vi_2x = coord_t'(x2);
    bus.vi_2y = coord_t'(y2);
    bus.vi_3x = coord_t'(x3);
    bus.vi_3y = coord_t'(y3);
  endtask
  task automatic wait_ready(input string nm);
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({nm, ":in_ready"}, longint'(bus.in_ready), 1);
  endtask
  task automatic accept(input int x1, y1, x2, y2, x3, y3, input string nm);
    wait_ready(nm);
    drive(x1, y1, x2, y2, x3, y3);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  // mode 0: always ready, 1: random ready, 2: stall 10 cycles at y=2, 3: garbage in_valid while busy
  task automatic run_tri(input int x1, y1, x2, y2, x3, y3, input int mode, input string nm);
    int k, idx, stall;
    bit seen, held, rdy;
    build(x1, y1, x2, y2, x3, y3);
    accept(x1, y1, x2, y2, x3, y3, nm);
    check({nm, ":busy"}, longint'(bus.busy), 1);
    check({nm, ":in_ready_busy"}, longint'(bus.in_ready), 0);
    k = 0;
    idx = 0;
    stall = 0;
    seen = 1'b0;
    held = 1'b0;
    while (idx < exp_q.size() && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
      if (held) check({nm, ":hold_valid"}, longint'(bus.span_valid), 1);
      held = 1'b0;
      if (mode == 3 && !seen) begin
        check({nm, ":ignored_err"}, longint'(bus.err_unsorted), 0);
        bus.in_valid = 1'b1;
        bus.vi_1y = 16'sd100;
        bus.vi_2y = -16'sd100;
      end
      if (bus.span_valid) begin
        bus.in_valid = 1'b0;
        if (!seen) check({nm, ":latency"}, k, 1 + 3 * DIV_CYCLES);
        seen = 1'b1;
        check({nm, ":y"}, bus.span_y, exp_q[idx].y);
        check({nm, ":xs"}, bus.span_xs, exp_q[idx].xs);
        check({nm, ":xe"}, bus.span_xe, exp_q[idx].xe);
        check({nm, ":last"}, longint'(bus.span_last), longint'(exp_q[idx].last));
        rdy = 1'b1;
        if (mode == 1) rdy = $urandom_range(2) != 0;
        if (mode == 2 && exp_q[idx].y == 2 && stall < 10) begin
          rdy = 1'b0;
          stall++;
        end
        bus.span_ready = rdy;
        if (rdy) idx++;
        else held = 1'b1;
      end else begin
        bus.span_ready = 1'($urandom_range(1));
      end
    end
    check({nm, ":rows"}, idx, exp_q.size());
    if (mode == 2) check({nm, ":stall_cycles"}, stall, 10);
    @(posedge clk);
    #1;
    bus.span_ready = 1'b0;
    check({nm, ":done_valid"}, longint'(bus.span_valid), 0);
    check({nm, ":done_in_ready"}, longint'(bus.in_ready), 1);
    check({nm, ":done_busy"}, longint'(bus.busy), 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int k;
    int x1, y1, x2, y2, x3, y3;
    bus.in_valid = 1'b0;
    bus.span_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst:in_ready", longint'(bus.in_ready), 0);
    check("rst:span_valid", longint'(bus.span_valid), 0);
    check("rst:span_last", longint'(bus.span_last), 0);
    check("rst:err", longint'(bus.err_unsorted), 0);
    check("rst:busy", longint'(bus.busy), 0);
    check("rst:span_y", bus.span_y, 0);
    check("rst:span_xs", bus.span_xs, 0);
    check("rst:span_xe", bus.span_xe, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel:in_ready", longint'(bus.in_ready), 1);
    run_tri(0, 0, -4, 4, 4, 4, 0, "flat");
    run_tri(2, 5, 9, 5, -3, 5, 0, "degen");
    run_tri(0, 0, 1, 3, 0, 3, 0, "posfrac");
    run_tri(0, 0, -1, 3, 0, 3, 0, "negfrac");
    run_tri(0, 0, -4, 4, 4, 4, 2, "bp");
    accept(0, 5, 0, 2, 0, 9, "unsorted");
    check("unsorted:err", longint'(bus.err_unsorted), 1);
    check("unsorted:in_ready", longint'(bus.in_ready), 1);
    check("unsorted:busy", longint'(bus.busy), 0);
    @(posedge clk);
    #1;
    check("unsorted:err_pulse", longint'(bus.err_unsorted), 0);
    repeat (5) @(posedge clk);
    #1;
    check("unsorted:no_span", longint'(bus.span_valid), 0);
    check("unsorted:still_idle", longint'(bus.busy), 0);
    run_tri(3, -2, -5, 1, 6, 7, 3, "ignore");
    accept(0, 0, -4, 4, 4, 4, "rst");
    bus.span_ready = 1'b1;
    k = 0;
    while (!(bus.span_valid && bus.span_y == 2) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst:reach_y2", bus.span_y, 2);
    bus.span_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid:span_valid", longint'(bus.span_valid), 0);
    check("rst_mid:in_ready", longint'(bus.in_ready), 0);
    check("rst_mid:busy", longint'(bus.busy), 0);
    check("rst_mid:span_y", bus.span_y, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel:in_ready", longint'(bus.in_ready), 1);
    run_tri(0, 0, -4, 4, 4, 4, 0, "after_rst");
    for (int t = 0; t < 25; t++) begin
      x1 = int'($urandom_range(80)) - 40;
      x2 = int'($urandom_range(80)) - 40;
      x3 = int'($urandom_range(80)) - 40;
      y1 = int'($urandom_range(40)) - 20;
      y2 = y1 + ($urandom_range(3) == 0 ? 0 : int'($urandom_range(7)));
      y3 = y2 + ($urandom_range(3) == 0 ? 0 : int'($urandom_range(7)));
      run_tri(x1, y1, x2, y2, x3, y3, 1, "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
